// File: rtl/uart_mem_loader.sv
// uart_mem_loader: UART byte-stream command decoder for sdpram load/readback.
// Optional MEM_LOADER_CHECKSUM_EN adds a checksum byte to WRITE frames.
module uart_mem_loader #(
  parameter int AddrBusWidth  = 6,
  parameter int DataBusWidth  = 4,
  parameter int TimeoutCycles = 80000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    rx_break,
  input  logic                    rx_error,
  output logic [AddrBusWidth-1:0] mem_addr,
  output logic                    mem_we,
  output logic [DataBusWidth-1:0] mem_w_data,
  output logic                    mem_re,
  input  logic [DataBusWidth-1:0] mem_r_data,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    frame_error
);

  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
`ifdef MEM_LOADER_CHECKSUM_EN
    GET_SUM,
`endif
    WRITE,
    READ,
    READ_CAP,
    REPLY
  } state_t;

  state_t        state;
  logic          cmd_w;
  logic          addr_ok;
  logic [TW-1:0] tmo;
  logic          in_range;
  logic          collecting;
  logic          counting;

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0] addr_b;
  logic [7:0] data_b;
  logic [7:0] sum;
  assign sum = addr_b + data_b + rx_data;
`endif

  assign in_range = (rx_data >> AddrBusWidth) == 8'd0;
  assign counting = (state == GET_ADDR) || (state == GET_DATA)
`ifdef MEM_LOADER_CHECKSUM_EN
                    || (state == GET_SUM)
`endif
                    ;
  assign collecting = counting || (state == IDLE);
  assign busy = (state != IDLE);

  // Frame decoder FSM with registered memory and reply outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cmd_w       <= 1'b0;
      addr_ok     <= 1'b0;
      tmo         <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_w_data  <= '0;
      mem_re      <= 1'b0;
      tx_data     <= 8'h00;
      tx_valid    <= 1'b0;
      frame_error <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
      addr_b      <= 8'h00;
      data_b      <= 8'h00;
`endif
    end else begin
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      frame_error <= 1'b0;
      tmo         <= '0;
      if (rx_break) begin
        state       <= IDLE;
        tx_valid    <= 1'b0;
        frame_error <= 1'b1;
      end else if (rx_error && collecting) begin
        state       <= REPLY;
        tx_data     <= NAK;
        tx_valid    <= 1'b1;
        frame_error <= 1'b1;
      end else begin
        if ((rx_valid || rx_error) && !collecting)
          frame_error <= 1'b1;
        if (counting && !rx_valid) begin
          if (tmo == TMO_LAST) begin
            state       <= IDLE;
            frame_error <= 1'b1;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        unique case (state)
          IDLE: if (rx_valid) begin
            cmd_w <= (rx_data == CMD_W);
            if (rx_data == CMD_W || rx_data == CMD_R) begin
              state <= GET_ADDR;
            end else begin
              state    <= REPLY;
              tx_data  <= NAK;
              tx_valid <= 1'b1;
            end
          end
          GET_ADDR: if (rx_valid) begin
            addr_ok <= in_range;
            if (in_range)
              mem_addr <= rx_data[AddrBusWidth-1:0];
`ifdef MEM_LOADER_CHECKSUM_EN
            addr_b <= rx_data;
`endif
            if (cmd_w) begin
              state <= GET_DATA;
            end else if (in_range) begin
              state  <= READ;
              mem_re <= 1'b1;
            end else begin
              state    <= REPLY;
              tx_data  <= NAK;
              tx_valid <= 1'b1;
            end
          end
          GET_DATA: if (rx_valid) begin
            mem_w_data <= rx_data[DataBusWidth-1:0];
`ifdef MEM_LOADER_CHECKSUM_EN
            data_b <= rx_data;
            state  <= GET_SUM;
          end
          GET_SUM: if (rx_valid) begin
            if (addr_ok && sum == 8'h00) begin
`else
            if (addr_ok) begin
`endif
              state  <= WRITE;
              mem_we <= 1'b1;
            end else begin
              state    <= REPLY;
              tx_data  <= NAK;
              tx_valid <= 1'b1;
            end
          end
          WRITE: begin
            state    <= REPLY;
            tx_data  <= ACK;
            tx_valid <= 1'b1;
          end
          READ: state <= READ_CAP;
          READ_CAP: begin
            state    <= REPLY;
            tx_data  <= 8'(mem_r_data);
            tx_valid <= 1'b1;
          end
          REPLY: if (tx_ready) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb_uart_mem_loader: directed scoreboard bench for uart_mem_loader.
// Build with MEM_LOADER_CHECKSUM_EN to exercise 4-byte WRITE frames.
module tb_uart_mem_loader;

  localparam int AW  = 6;
  localparam int DW  = 4;
  localparam int TMO = 40;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_break = 1'b0;
  logic          rx_error = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_w_data;
  logic          mem_re;
  logic [DW-1:0] mem_r_data = '0;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready = 1'b1;
  logic          busy;
  logic          frame_error;

  int vectors = 0;
  int errors  = 0;
  int we_cnt = 0, re_cnt = 0, fe_cnt = 0, tx_cnt = 0;
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [DW-1:0] mem [2**AW];

  uart_mem_loader #(
    .AddrBusWidth(AW), .DataBusWidth(DW), .TimeoutCycles(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_break(rx_break), .rx_error(rx_error),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_w_data(mem_w_data), .mem_re(mem_re),
    .mem_r_data(mem_r_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 2**AW; i++) mem[i] = '0;

  // simple sdpram model: write port A, registered read port
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_w_data;
    if (mem_re) mem_r_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: replies and writes against expected queues
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        if (exp_tx.size() == 0) check("tx_unexpected", tx_data, 32'hFFFF);
        else check("tx_data", tx_data, exp_tx.pop_front());
      end
      if (mem_we) begin
        logic [15:0] e;
        we_cnt++;
        if (exp_wr.size() == 0) check("wr_unexpected", mem_addr, 32'hFFFF);
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", mem_addr, e[15:8]);
          check("wr_data", mem_w_data, e[7:0]);
        end
      end
      if (mem_re) re_cnt++;
      if (frame_error) fe_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'h57);
    send_byte(a);
    send_byte(d);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 - a - d);
`endif
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || tx_valid) && n < 300) begin
      tick();
      n++;
    end
    check(tag, busy | tx_valid, 0);
  endtask

  initial begin
    int we0, re0, fe0, tx0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_we_re", {mem_we, mem_re}, 0);
    check("rst_ferr", frame_error, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_w_data, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;
    tick();

    we0 = we_cnt;
    exp_wr.push_back({8'h05, 8'h0A});
    exp_tx.push_back(8'h06);
    wr_frame(8'h05, 8'h0A);
    check("wr_we_latency", mem_we, 1);
    check("wr_busy", busy, 1);
    tick();
    check("wr_we_pulse", mem_we, 0);
    check("wr_tx_latency", tx_valid, 1);
    check("wr_ack", tx_data, 8'h06);
    wait_idle("wr_idle");
    check("wr_count", we_cnt - we0, 1);

    re0 = re_cnt;
    exp_tx.push_back(8'h0A);
    send_byte(8'h52);
    send_byte(8'h05);
    check("rd_re", mem_re, 1);
    check("rd_addr", mem_addr, 5);
    tick();
    check("rd_re_pulse", mem_re, 0);
    check("rd_tx_early", tx_valid, 0);
    tick();
    check("rd_tx_latency", tx_valid, 1);
    check("rd_data", tx_data, 8'h0A);
    wait_idle("rd_idle");
    check("rd_count", re_cnt - re0, 1);

    we0 = we_cnt; re0 = re_cnt;
    exp_tx.push_back(8'h15);
    send_byte(8'h41);
    wait_idle("bad_cmd_idle");
    exp_tx.push_back(8'h15);
    wr_frame(8'h40, 8'h03);
    wait_idle("oor_idle");
    check("nak_no_mem", (we_cnt - we0) + (re_cnt - re0), 0);

    fe0 = fe_cnt; tx0 = tx_cnt;
    send_byte(8'h57);
    repeat (TMO - 1) tick();
    check("tmo_not_early", busy, 1);
    tick();
    check("tmo_idle", busy, 0);
    check("tmo_ferr", frame_error, 1);
    repeat (3) tick();
    check("tmo_ferr_count", fe_cnt - fe0, 1);
    check("tmo_no_reply", tx_cnt - tx0 + tx_valid, 0);
    exp_wr.push_back({8'h01, 8'h02});
    exp_tx.push_back(8'h06);
    wr_frame(8'h01, 8'h02);
    wait_idle("tmo_next_idle");

    send_byte(8'h57);
    send_byte(8'h05);
    tick();
    rx_break = 1'b1;
    tick();
    rx_break = 1'b0;
    check("brk_idle", busy, 0);
    check("brk_ferr", frame_error, 1);

    tx_ready = 1'b0;
    exp_wr.push_back({8'h07, 8'h0C});
    wr_frame(8'h07, 8'h0C);
    tick();
    repeat (5) tick();
    check("hold_tx_valid", tx_valid, 1);
    check("hold_tx_data", tx_data, 8'h06);
    rx_break = 1'b1;
    tick();
    rx_break = 1'b0;
    check("brk_reply_drop", tx_valid, 0);
    check("brk_reply_idle", busy, 0);

    exp_wr.push_back({8'h08, 8'h03});
    wr_frame(8'h08, 8'h03);
    tick();
    send_byte(8'h41);
    check("ovr_ferr", frame_error, 1);
    check("ovr_state", {busy, tx_valid}, 2'b11);
    check("ovr_tx_data", tx_data, 8'h06);
    exp_tx.push_back(8'h06);
    tx_ready = 1'b1;
    wait_idle("ovr_idle");

    re0 = re_cnt;
    exp_tx.push_back(8'h15);
    send_byte(8'h52);
    tick();
    rx_data = 8'h05; rx_valid = 1'b1; rx_error = 1'b1;
    tick();
    rx_valid = 1'b0; rx_error = 1'b0;
    check("rxerr_ferr", frame_error, 1);
    check("rxerr_nak", tx_data, 8'h15);
    wait_idle("rxerr_idle");
    check("rxerr_no_re", re_cnt - re0, 0);

    exp_wr.push_back({8'h09, 8'h05});
    exp_tx.push_back(8'h06);
    wr_frame(8'h09, 8'hF5);
    wait_idle("hi_bits_idle");
    exp_tx.push_back(8'h0C);
    send_byte(8'h52); send_byte(8'h07);
    wait_idle("rd7_idle");
    exp_tx.push_back(8'h03);
    send_byte(8'h52); send_byte(8'h08);
    wait_idle("rd8_idle");
    exp_tx.push_back(8'h02);
    send_byte(8'h52); send_byte(8'h01);
    wait_idle("rd1_idle");
    exp_tx.push_back(8'h05);
    send_byte(8'h52); send_byte(8'h09);
    wait_idle("rd9_idle");

`ifdef MEM_LOADER_CHECKSUM_EN
    we0 = we_cnt;
    exp_tx.push_back(8'h15);
    send_byte(8'h57); send_byte(8'h05);
    send_byte(8'h0A); send_byte(8'hF0);
    wait_idle("sum_bad_idle");
    check("sum_bad_no_we", we_cnt - we0, 0);
    exp_wr.push_back({8'h05, 8'h0A});
    exp_tx.push_back(8'h06);
    send_byte(8'h57); send_byte(8'h05);
    send_byte(8'h0A); send_byte(8'hF1);
    wait_idle("sum_ok_idle");
`endif

    tick();
    rx_data = 8'h57; rx_valid = 1'b1; rx_break = 1'b1;
    tick();
    rx_valid = 1'b0; rx_break = 1'b0;
    check("brk_prio_idle", busy, 0);
    check("brk_prio_ferr", frame_error, 1);

    repeat (3) tick();
    check("sb_tx_empty", exp_tx.size(), 0);
    check("sb_wr_empty", exp_wr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
